// File: rtl/jesd204b_pkg.sv
// Shared constants, SYSREF mode encoding and a small modulo helper for the
// JESD204B LMFC / frame-marker block.
package jesd204b_pkg;

  localparam int F_W = 8;
  localparam int K_W = 5;
  localparam int M_W = 13;

  typedef enum logic [1:0] {
    SYSREF_IGNORE  = 2'd0,
    SYSREF_ONESHOT = 2'd1,
    SYSREF_CONT    = 2'd2,
    SYSREF_IGNORE3 = 2'd3
  } sysref_mode_e;

  // Reduces v modulo m by repeated subtraction; valid while v < 9*m, which
  // holds for a frame-octet index plus at most 8 octets of advance.
  function automatic logic [F_W:0] wrap_mod(input logic [F_W:0] v, input logic [F_W:0] m);
    logic [F_W:0] r;
    r = v;
    for (int j = 0; j < 8; j++) begin
      if (r >= m) r = r - m;
    end
    return r;
  endfunction

endpackage

// File: rtl/jesd204b_lmfc_ctrl_if.sv
// Link-configuration inputs, SYSREF and the LMFC / per-octet marker outputs.
// master = the LMFC generator, slave = the link layer that consumes its timing.
interface jesd204b_lmfc_ctrl_if
  import jesd204b_pkg::*;
#(
  parameter int OCTET_PER_SENT = 4,
  parameter int CNT_WIDTH      = 10
);

  logic [F_W-1:0]            cfg_f;
  logic [K_W-1:0]            cfg_k;
  logic [3:0]                cfg_early0;
  logic [3:0]                cfg_early1;
  logic [1:0]                sysref_mode;
  logic                      sysref;
  logic                      lmfc;
  logic                      lmfc_early0;
  logic                      lmfc_early1;
  logic [OCTET_PER_SENT-1:0] sof;
  logic [OCTET_PER_SENT-1:0] eof;
  logic [OCTET_PER_SENT-1:0] som;
  logic [OCTET_PER_SENT-1:0] eom;
  logic [CNT_WIDTH-1:0]      beat_cnt;
  logic                      sysref_aligned;
  logic                      sysref_err;
  logic                      cfg_err;

  modport master (
    input  cfg_f, cfg_k, cfg_early0, cfg_early1, sysref_mode, sysref,
    output lmfc, lmfc_early0, lmfc_early1, sof, eof, som, eom, beat_cnt,
           sysref_aligned, sysref_err, cfg_err
  );

  modport slave (
    output cfg_f, cfg_k, cfg_early0, cfg_early1, sysref_mode, sysref,
    input  lmfc, lmfc_early0, lmfc_early1, sof, eof, som, eom, beat_cnt,
           sysref_aligned, sysref_err, cfg_err
  );

endinterface

// File: rtl/jesd204b_framemark_dec.sv
// Per-octet start/end-of-frame decode from the frame-octet index of octet 0.
module jesd204b_framemark_dec
  import jesd204b_pkg::*;
#(
  parameter int OCTET_PER_SENT = 4
) (
  input  logic [F_W-1:0]            fo,
  input  logic [F_W-1:0]            f,
  output logic [OCTET_PER_SENT-1:0] sof,
  output logic [OCTET_PER_SENT-1:0] eof
);

  localparam int FW1 = F_W + 1;

  for (genvar i = 0; i < OCTET_PER_SENT; i++) begin : g_octet
    logic [FW1-1:0] idx;
    assign idx    = wrap_mod(FW1'(fo) + FW1'(i), FW1'(f) + FW1'(1));
    assign sof[i] = (idx == '0);
    assign eof[i] = (idx == FW1'(f));
  end

endmodule

// File: rtl/jesd204b_lmfc_ctrl.sv
// Runtime-configurable LMFC counter, look-ahead pulses, SYSREF alignment and
// per-octet frame/multiframe markers for the JESD204B data-link layer.
module jesd204b_lmfc_ctrl
  import jesd204b_pkg::*;
#(
  parameter int OCTET_PER_SENT = 4,
  parameter int CNT_WIDTH      = 10
) (
  input logic                  clk,
  input logic                  reset,
  jesd204b_lmfc_ctrl_if.master bus
);

  localparam int SH  = $clog2(OCTET_PER_SENT);
  localparam int EW  = ((CNT_WIDTH > M_W) ? CNT_WIDTH : M_W) + 1;
  localparam int FW1 = F_W + 1;

  logic [F_W-1:0]            f_q;
  logic [K_W-1:0]            k_q;
  logic [3:0]                early0_q;
  logic [3:0]                early1_q;
  sysref_mode_e              mode_q;
  logic [M_W-1:0]            m_len;
  logic [M_W-1:0]            b_len;
  logic [EW-1:0]             b_ext;
  logic [EW-1:0]             cnt_ext;
  logic [EW-1:0]             early0_at;
  logic [EW-1:0]             early1_at;
  logic                      cfg_bad;
  logic                      valid;
  logic                      at_last;
  logic                      sysref_q;
  logic                      sysref_edge;
  logic                      realign;
  logic                      aligned_q;
  logic                      err_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [F_W-1:0]            fo_q;
  logic [OCTET_PER_SENT-1:0] sof_raw;
  logic [OCTET_PER_SENT-1:0] eof_raw;
  logic [OCTET_PER_SENT-1:0] som_v;
  logic [OCTET_PER_SENT-1:0] eom_v;

  // Configuration tracks the inputs only while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q      <= bus.cfg_f;
      k_q      <= bus.cfg_k;
      early0_q <= bus.cfg_early0;
      early1_q <= bus.cfg_early1;
      mode_q   <= sysref_mode_e'(bus.sysref_mode);
    end
  end

  always_comb begin
    m_len   = M_W'((32'(f_q) + 32'd1) * (32'(k_q) + 32'd1));
    b_len   = m_len >> SH;
    b_ext   = EW'(b_len);
    cnt_ext = EW'(cnt_q);
    cfg_bad = ((m_len & M_W'(OCTET_PER_SENT - 1)) != '0)
            || (b_ext > (EW'(1) << CNT_WIDTH))
            || (EW'(early0_q) >= b_ext)
            || (EW'(early1_q) >= b_ext);
    at_last   = (cnt_ext == b_ext - EW'(1));
    early0_at = (early0_q == 4'd0) ? '0 : b_ext - EW'(early0_q);
    early1_at = (early1_q == 4'd0) ? '0 : b_ext - EW'(early1_q);
    valid     = ~reset & ~cfg_bad;
  end

  assign sysref_edge = bus.sysref & ~sysref_q & ~cfg_bad;
  assign realign     = sysref_edge
                     & (((mode_q == SYSREF_ONESHOT) & ~aligned_q) | (mode_q == SYSREF_CONT));

  // fo advances by one beat's worth of octets, modulo the frame length.
  always_ff @(posedge clk) begin
    if (reset || cfg_bad || realign) begin
      cnt_q <= '0;
      fo_q  <= '0;
    end else begin
      cnt_q <= at_last ? '0 : cnt_q + CNT_WIDTH'(1);
      fo_q  <= F_W'(wrap_mod(FW1'(fo_q) + FW1'(OCTET_PER_SENT), FW1'(f_q) + FW1'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sysref_q  <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sysref_q <= bus.sysref;
      if (realign) aligned_q <= 1'b1;
      // A continuous-mode edge is only in phase when it lands on the last beat.
      if (sysref_edge && (mode_q == SYSREF_CONT) && !at_last) err_q <= 1'b1;
    end
  end

  jesd204b_framemark_dec #(
    .OCTET_PER_SENT(OCTET_PER_SENT)
  ) u_dec (
    .fo  (fo_q),
    .f   (f_q),
    .sof (sof_raw),
    .eof (eof_raw)
  );

  always_comb begin
    som_v                   = '0;
    eom_v                   = '0;
    som_v[0]                = valid & (cnt_ext == '0);
    eom_v[OCTET_PER_SENT-1] = valid & at_last;
  end

  assign bus.lmfc           = valid & (cnt_ext == '0);
  assign bus.lmfc_early0    = valid & (cnt_ext == early0_at);
  assign bus.lmfc_early1    = valid & (cnt_ext == early1_at);
  assign bus.beat_cnt       = valid ? cnt_q : '0;
  assign bus.sof            = valid ? sof_raw : '0;
  assign bus.eof            = valid ? eof_raw : '0;
  assign bus.som            = som_v;
  assign bus.eom            = eom_v;
  assign bus.sysref_aligned = ~reset & aligned_q;
  assign bus.sysref_err     = ~reset & err_q;
  assign bus.cfg_err        = ~reset & cfg_bad;

endmodule

// File: doc/jesd204b_lmfc_ctrl.md
# jesd204b_lmfc_ctrl

Parametrised LMFC and frame-marker generator for the JESD204B data-link layer. Replaces the fixed compile-time LMFC counter and frame-marker logic with:
- runtime F/K from the link configuration fields;
- any power-of-two octets-per-beat width;
- two programmable LMFC look-ahead pulses;
- SYSREF-based phase alignment with error detection.

It sits at the data-link top level and drives the per-lane TX/RX LMFC inputs and the per-octet SOF/EOF/SOM/EOM buses.

## Interface
Parameters:
- OCTET_PER_SENT, 4: octets per clock beat; legal values 1, 2, 4, 8.
- CNT_WIDTH, 10: beat counter width; maximum multiframe length is 2^CNT_WIDTH beats.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- cfg_f  in  8  F-1 (octets per frame minus one), JESD encoding.
- cfg_k  in  5  K-1 (frames per multiframe minus one).
- cfg_early0  in  4  lead, in beats, of lmfc_early0 before lmfc.
- cfg_early1  in  4  lead, in beats, of lmfc_early1 before lmfc.
- sysref_mode  in  2  0 = ignore, 1 = one-shot, 2 = continuous, 3 = same as 0.
- sysref  in  1  SYSREF, already synchronous to clk.
- lmfc  out  1  high in the first beat of each multiframe.
- lmfc_early0, lmfc_early1  out  1  look-ahead pulses.
- sof, eof, som, eom  out  OCTET_PER_SENT  bit i marks octet i of the current beat.
- beat_cnt  out  CNT_WIDTH  beat index within the multiframe.
- sysref_aligned  out  1  a SYSREF edge has aligned the counters.
- sysref_err  out  1  sticky; a continuous-mode SYSREF edge arrived off-phase.
- cfg_err  out  1  configuration illegal.

## Operation
- Configuration is registered every cycle while reset = 1 and held while reset = 0; later input changes are ignored.
- Multiframe and counters:
  - M = (cfg_f+1)*(cfg_k+1), 13 bits unsigned.
  - B = M / OCTET_PER_SENT, computed by shift.
  - beat_cnt counts 0..B-1 and wraps.
  - fo holds the frame-octet index of octet 0; it advances by OCTET_PER_SENT mod (F+1) each beat (F may be smaller than OCTET_PER_SENT).
- cfg_err = 1 when any of the following holds; while cfg_err = 1, counters are held at 0 and all markers and pulses are 0:
  - M mod OCTET_PER_SENT != 0;
  - B > 2^CNT_WIDTH;
  - cfg_early0 >= B;
  - cfg_early1 >= B.
- Decodes:
  - lmfc = (beat_cnt == 0).
  - lmfc_earlyN = (beat_cnt == (B - cfg_earlyN) mod B); a lead of 0 coincides with lmfc.
  - sof[i] = ((fo+i) mod (F+1) == 0).
  - eof[i] = ((fo+i) mod (F+1) == F).
  - som[0] = lmfc, other som bits 0.
  - eom[OCTET_PER_SENT-1] = (beat_cnt == B-1), other eom bits 0.
- SYSREF:
  - Edge = sysref & ~sysref_q, where sysref_q is sysref registered.
  - Realignment on an edge: beat_cnt and fo load 0 at the end of that cycle.
  - Mode 1: only the first edge after reset realigns and sets sysref_aligned; later edges are ignored.
  - Mode 2: every edge realigns. If beat_cnt != B-1 on the edge cycle, sysref_err is set (sticky until reset). sysref_aligned is set on the first edge.
  - Modes 0 and 3: edges are ignored and sysref_aligned stays 0.
  - An edge during reset is ignored.

## Timing
- Reset values: beat_cnt = 0, fo = 0, sysref_q = 0, sysref_aligned = 0, sysref_err = 0. All outputs are 0 while reset = 1 (decodes gated).
- The first cycle after reset falls has beat_cnt = 0, so lmfc = 1.
- Outputs decode registered state only; there is no input-to-output combinational path except cfg_err.
- SYSREF edge in cycle N → lmfc = 1 in cycle N+1.
- An edge coinciding with a natural wrap produces no extra or missing lmfc pulse.
- Reset mid-multiframe takes effect on the next edge; the lmfc count restarts exactly as from power-up.

## Structure
- Package jesd204b_pkg holds:
  - SYSREF mode constants (SYSREF_IGNORE, SYSREF_ONESHOT, SYSREF_CONT);
  - config field widths (F_W = 8, K_W = 5, M_W = 13).
- Sub-module jesd204b_framemark_dec: purely combinational per-octet sof/eof decode from fo and F, one generate loop over OCTET_PER_SENT.
- The top level holds the config registers, the beat/fo counters, the SYSREF logic and the error flags.

## Test plan
- cfg_f = 3, cfg_k = 4, OCTET_PER_SENT = 4 (B = 5):
  - lmfc every 5 cycles starting the cycle after reset release;
  - sof = 0001 and eof = 1000 every beat;
  - som = 0001 and eom = 1000 on beats 0 and 4 respectively.
- cfg_f = 2, cfg_k = 3 (M = 12, B = 3):
  - sof sequence 1001, 0100, 0010, repeating;
  - eof sequence 0100, 0010, 1001, repeating.
- cfg_f = 1, cfg_k = 15, cfg_early0 = 2, cfg_early1 = 0 (B = 8):
  - lmfc_early0 at beat_cnt 6;
  - lmfc_early1 coincident with lmfc.
- sysref_mode = 2, edge at beat_cnt = 2 → beat_cnt = 0 and lmfc = 1 next cycle, sysref_err = 1 and stays 1. A later edge at beat_cnt = 4 (B = 5) → no error change and lmfc spacing unchanged.
- sysref_mode = 1, two edges 7 cycles apart: the first realigns, the second is ignored; sysref_aligned = 1.
- cfg_f = 4, cfg_k = 4 (M = 25) → cfg_err = 1; all markers and lmfc stay 0 for 50 cycles.
